// File: rtl/pe64_grant_arbiter_if.sv
// Request/grant bundle between the requesting agents (master) and the
// 64-way grant arbiter (slave).
interface pe64_grant_arbiter_if;
  logic [63:0] req;
  logic        done;
  logic [63:0] gnt;
  logic [5:0]  gnt_idx;
  logic        gnt_vld;
  logic        timeout;
  logic        busy;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_vld, timeout, busy
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_vld, timeout, busy
  );
endinterface

// File: rtl/pe64_grant_arbiter.sv
// 64-requester grant arbiter: highest-index-wins encoder, registered grant held
// until done/request drop/hold limit. Define PE64_ARB_RR_EN for round-robin.
module pe64_grant_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  pe64_grant_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam bit               HOLD_EN  = (HOLD_MAX != 0);

  state_t            state_p1, state_nx;
  logic [63:0]       gnt_p1, gnt_nx;
  logic [5:0]        gnt_idx_p1, gnt_idx_nx;
  logic              vld_p1, vld_nx;
  logic              timeout_p1, timeout_nx;
  logic [CNT_W-1:0]  hold_cnt_p1, hold_cnt_nx;

  logic [63:0]       req_eff;
  logic [5:0]        win;
  logic              rel;
  logic              lim;

  function automatic logic [5:0] enc64(input logic [63:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (v[i]) r = 6'(i);
    return r;
  endfunction

`ifdef PE64_ARB_RR_EN
  logic [5:0]  last_p1;
  logic [63:0] req_msk;
  logic [5:0]  win_msk;
  logic [5:0]  win_all;

  // Only indices below the last winner are eligible; wrap to the full vector when none are.
  always_comb begin
    req_msk = bus.req & ((64'd1 << last_p1) - 64'd1);
    win_msk = enc64(req_msk);
    win_all = enc64(bus.req);
    req_eff = (|req_msk) ? req_msk : bus.req;
    win     = (|req_msk) ? win_msk : win_all;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_p1 <= '0;
    else if (state_p1 == IDLE && (|req_eff))
      last_p1 <= win;
  end
`else
  assign req_eff = bus.req;
  assign win     = enc64(bus.req);
`endif

  assign rel = bus.done | ~bus.req[gnt_idx_p1];
  assign lim = HOLD_EN && (hold_cnt_p1 == HOLD_LIM);

  // ---- stage p1: state register and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1    <= IDLE;
      gnt_p1      <= '0;
      gnt_idx_p1  <= '0;
      vld_p1      <= 1'b0;
      timeout_p1  <= 1'b0;
      hold_cnt_p1 <= '0;
    end else begin
      state_p1    <= state_nx;
      gnt_p1      <= gnt_nx;
      gnt_idx_p1  <= gnt_idx_nx;
      vld_p1      <= vld_nx;
      timeout_p1  <= timeout_nx;
      hold_cnt_p1 <= hold_cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_p1;
    case (state_p1)
      IDLE:    if (|req_eff) state_nx = GRANT;
      GRANT:   if (rel || lim) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Normal release takes precedence over the hold limit, so timeout stays low then.
  always_comb begin
    gnt_idx_nx  = gnt_idx_p1;
    vld_nx      = vld_p1;
    hold_cnt_nx = hold_cnt_p1;
    timeout_nx  = 1'b0;
    case (state_p1)
      IDLE: begin
        if (|req_eff) begin
          gnt_idx_nx  = win;
          vld_nx      = 1'b1;
          hold_cnt_nx = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          vld_nx = 1'b0;
        end else if (lim) begin
          vld_nx     = 1'b0;
          timeout_nx = 1'b1;
        end else if (hold_cnt_p1 != {CNT_W{1'b1}}) begin
          hold_cnt_nx = hold_cnt_p1 + CNT_W'(1);
        end
      end
      GAP:     vld_nx = 1'b0;
      default: vld_nx = 1'b0;
    endcase
    gnt_nx = vld_nx ? (64'd1 << gnt_idx_nx) : 64'd0;
  end

  assign bus.gnt     = gnt_p1;
  assign bus.gnt_idx = gnt_idx_p1;
  assign bus.gnt_vld = vld_p1;
  assign bus.timeout = timeout_p1;
  assign bus.busy    = (state_p1 != IDLE);

endmodule

// File: tb/tb_pe64_grant_arbiter.sv
// Scoreboard bench for pe64_grant_arbiter: directed scenarios plus random
// request/done traffic against an owner/held-cycles reference model.
module tb_pe64_grant_arbiter;

  localparam int HM = 4;
`ifdef PE64_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [63:0] gnt;
    logic [5:0]  idx;
    logic        vld;
    logic        tmo;
    logic        busy;
  } exp_t;

  logic clk;
  logic rst;
  pe64_grant_arbiter_if bus();

  pe64_grant_arbiter #(.HOLD_MAX(HM), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  // reference model: current owner (-1 = none), cycles it has been visible, gap flag
  int m_owner, m_held, m_idx, m_ptr;
  bit m_gap, m_tmo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req_v, $time);
    end
  endtask

  function automatic int pick(input logic [63:0] r, input int ptr);
    logic [63:0] m;
    logic [63:0] v;
    m = r & ((64'd1 << ptr) - 64'd1);
    v = (RR && m != 64'd0) ? m : r;
    for (int i = 63; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_idx = 0; m_ptr = 0; m_gap = 0; m_tmo = 0;
    q.delete();
  endtask

  // Apply inputs for the coming edge and queue what the outputs must be after it.
  task automatic drive(input logic [63:0] r, input logic d);
    exp_t e;
    int   w;
    bus.req  = r;
    bus.done = d;
    m_tmo    = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      if (r != 64'd0) begin
        w = pick(r, m_ptr);
        m_owner = w; m_held = 1; m_idx = w; m_ptr = w;
      end
    end else if (d || !r[m_owner]) begin
      m_owner = -1; m_gap = 1;
    end else if (m_held == HM) begin
      m_owner = -1; m_gap = 1; m_tmo = 1;
    end else begin
      m_held++;
    end
    e.vld  = (m_owner >= 0);
    e.gnt  = (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
    e.idx  = 6'(m_idx);
    e.tmo  = m_tmo;
    e.busy = (m_owner >= 0) || m_gap;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [63:0] r, input logic d);
    @(negedge clk);
    drive(r, d);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},     bus.gnt, 64'd0);
    chk({tag, "_gnt_idx"}, 64'(bus.gnt_idx), 64'd0);
    chk({tag, "_gnt_vld"}, 64'(bus.gnt_vld), 64'd0);
    chk({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
    chk({tag, "_busy"},    64'(bus.busy), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("gnt",     bus.gnt, mon_e.gnt);
      chk("gnt_idx", 64'(bus.gnt_idx), 64'(mon_e.idx));
      chk("gnt_vld", 64'(bus.gnt_vld), 64'(mon_e.vld));
      chk("timeout", 64'(bus.timeout), 64'(mon_e.tmo));
      chk("busy",    64'(bus.busy), 64'(mon_e.busy));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rq;
    logic [63:0] b;
    rst      = 1'b1;
    bus.req  = '1;
    bus.done = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      chk_zero("reset_hold");
    end

    // release reset with every requester active: index 63 must win
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive('1, 1'b0);
    cyc('1, 1'b0);
    cyc('1, 1'b1);
    cyc(64'd0, 1'b0);
    cyc(64'd0, 1'b0);

    // bits 5 and 40: grant 40, release, one-cycle gap, then the next winner
    b = (64'd1 << 5) | (64'd1 << 40);
    cyc(b, 1'b0);
    cyc(b, 1'b0);
    cyc(b, 1'b1);
    cyc(b, 1'b0);
    cyc(b, 1'b0);
    cyc(b, 1'b1);
    cyc(64'd0, 1'b0);
    cyc(64'd0, 1'b0);

    // hold limit on requester 10, then regrant after the gap
    b = 64'd1 << 10;
    repeat (12) cyc(b, 1'b0);
    cyc(64'd0, 1'b1);
    cyc(64'd0, 1'b0);
    cyc(64'd0, 1'b0);

    // done on the last allowed grant cycle: normal release, no timeout
    repeat (4) cyc(b, 1'b0);
    cyc(b, 1'b1);
    cyc(64'd0, 1'b0);
    cyc(64'd0, 1'b0);

    // request drop by owner 7; a raised req[63] must not preempt
    cyc(64'd1 << 7, 1'b0);
    cyc((64'd1 << 7) | (64'd1 << 63), 1'b0);
    cyc(64'd1 << 63, 1'b0);
    cyc(64'd1 << 63, 1'b0);
    cyc(64'd1 << 63, 1'b0);
    cyc(64'd1 << 63, 1'b1);
    cyc(64'd0, 1'b0);
    cyc(64'd0, 1'b0);

    // asynchronous reset in the middle of a grant
    b = 64'd1 << 20;
    cyc(b, 1'b0);
    cyc(b, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    chk_zero("async_reset_hold");
    rst = 1'b0;
    model_reset();
    drive(64'd0, 1'b0);

    // requesters 0..2 with done every grant: rotation under round-robin
    rq = 64'h7;
    repeat (4) begin
      cyc(rq, 1'b0);
      cyc(rq, 1'b1);
      cyc(rq, 1'b0);
    end
    cyc(64'd0, 1'b0);
    cyc(64'd0, 1'b0);

    // random traffic
    rq = 64'd0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: rq = {$urandom, $urandom};
          1: rq = 64'd1 << $urandom_range(0, 63);
          2: rq = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63))
                | (64'd1 << $urandom_range(0, 63));
          default: rq = 64'd0;
        endcase
      end
      cyc(rq, ($urandom_range(0, 5) == 0));
    end

    @(posedge clk); #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
